// File: rtl/if_prefetch.sv
// Instruction prefetch buffer: credit-limited in-order fetch with redirect/drain handling.
// Define IF_PERF_CNT_EN to add the fetch_count output (count of delivered instructions).
module if_prefetch #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] PC_RESET   = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_ready,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
`ifdef IF_PERF_CNT_EN
  output logic [31:0]           fetch_count,
`endif
  output logic                  ir_valid,
  output logic [DATA_WIDTH-1:0] ir,
  output logic [ADDR_WIDTH-1:0] ir_pc,
  input  logic                  ir_ready
);

  localparam int unsigned           PtrW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned           CntW   = $clog2(DEPTH + 1);
  localparam logic [ADDR_WIDTH-1:0] PcInc  = ADDR_WIDTH'(DATA_WIDTH / 8);
  localparam logic [CntW:0]         DepthC = (CntW + 1)'(DEPTH);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_WIDTH-1:0] resp_pc_q, resp_pc_d;
  logic [CntW-1:0]       outstanding_q, outstanding_d;
  logic [CntW-1:0]       drop_cnt_q, drop_cnt_d;
  logic [CntW-1:0]       count_q, count_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;

  logic [DATA_WIDTH-1:0] buf_data [DEPTH];
  logic [ADDR_WIDTH-1:0] buf_pc   [DEPTH];

  logic [CntW:0] inflight, pending;
  logic          accept, rsp_any, rsp_drop, push, pop;

  always_comb begin
    inflight = {1'b0, count_q} + {1'b0, outstanding_q};
    // Stale responses are always older than live ones, so the oldest arrival drains first.
    pending  = {1'b0, drop_cnt_q} + {1'b0, outstanding_q};
    mem_req  = (state_q == StRun) && (inflight < DepthC) && !redirect_valid;
    mem_addr = fetch_pc_q;
    accept   = mem_req && mem_ready;
    rsp_any  = mem_rvalid && (pending != '0);
    rsp_drop = mem_rvalid && (drop_cnt_q != '0);
    push     = mem_rvalid && (drop_cnt_q == '0) && (outstanding_q != '0) && !redirect_valid;
    ir_valid = (count_q != '0);
    pop      = ir_valid && ir_ready && !redirect_valid;
    ir       = ir_valid ? buf_data[rd_ptr_q] : '0;
    ir_pc    = ir_valid ? buf_pc[rd_ptr_q] : '0;
  end

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    outstanding_d = outstanding_q;
    drop_cnt_d    = drop_cnt_q;
    count_d       = count_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    if (redirect_valid) begin
      fetch_pc_d    = redirect_pc;
      resp_pc_d     = redirect_pc;
      outstanding_d = '0;
      drop_cnt_d    = CntW'(pending - {{CntW{1'b0}}, rsp_any});
      count_d       = '0;
      rd_ptr_d      = '0;
      wr_ptr_d      = '0;
      state_d       = (drop_cnt_d != '0) ? StDrain : StRun;
    end else begin
      if (accept) fetch_pc_d = fetch_pc_q + PcInc;
      outstanding_d = outstanding_q + CntW'(accept) - CntW'(push);
      if (rsp_drop) drop_cnt_d = drop_cnt_q - CntW'(1);
      if (push) begin
        resp_pc_d = resp_pc_q + PcInc;
        wr_ptr_d  = wr_ptr_q + PtrW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PtrW'(1);
      count_d = count_q + CntW'(push) - CntW'(pop);
      case (state_q)
        StIdle:  state_d = StRun;
        StRun:   state_d = StRun;
        StDrain: if (drop_cnt_d == '0) state_d = StRun;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      fetch_pc_q    <= PC_RESET;
      resp_pc_q     <= PC_RESET;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
    end
  end

  // Payload storage needs no reset: entries are only visible while counted.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_data[wr_ptr_q] <= mem_rdata;
      buf_pc[wr_ptr_q]   <= resp_pc_q;
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_count_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_count_q <= '0;
    end else if (pop) begin
      fetch_count_q <= fetch_count_q + 32'd1;
    end
  end

  assign fetch_count = fetch_count_q;
`endif

endmodule

// File: tb/tb_if_prefetch.sv
// Scoreboard bench for if_prefetch: directed fetch, stall, redirect, reset and stray-response cases.
module tb_if_prefetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        ir_valid;
  logic [31:0] ir;
  logic [31:0] ir_pc;
  logic        ir_ready;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_count;
`endif

  if_prefetch dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_ready      (mem_ready),
    .mem_rvalid     (mem_rvalid),
    .mem_rdata      (mem_rdata),
`ifdef IF_PERF_CNT_EN
    .fetch_count    (fetch_count),
`endif
    .ir_valid       (ir_valid),
    .ir             (ir),
    .ir_pc          (ir_pc),
    .ir_ready       (ir_ready)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          budget;
  logic        mem_hold;
  int          stray_req;
  int          stray_done;
  logic [31:0] sb [$];
  logic [31:0] pend [$];
  logic [31:0] acc_log [$];

  function automatic logic [31:0] rdata_of(logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_pcs(logic [31:0] first, int n);
    for (int i = 0; i < n; i++) sb.push_back(first + 32'(4 * i));
  endtask

  task automatic wait_sb(int maxc);
    int i = 0;
    while (sb.size() != 0 && i < maxc) begin
      @(negedge clk);
      i++;
    end
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
  endtask

  task automatic wait_rvalid(int maxc);
    int i = 0;
    do begin
      @(negedge clk);
      i++;
    end while (!mem_rvalid && i < maxc);
    chk("rvalid_seen", 64'(mem_rvalid), 64'd1);
  endtask

  // Memory model: in-order, one response per cycle, at least one cycle after acceptance.
  initial begin
    logic        acc;
    logic        hold_s;
    logic [31:0] a;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    stray_done = 0;
    forever begin
      @(negedge clk);
      acc    = mem_req && mem_ready && reset;
      a      = mem_addr;
      hold_s = mem_hold;
      @(posedge clk);
      if (!reset) begin
        pend.delete();
      end else if (acc) begin
        pend.push_back(a);
        acc_log.push_back(a);
      end
      #1;
      if (!reset) begin
        mem_rvalid = 1'b0;
      end else if (!hold_s && pend.size() > 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = rdata_of(pend.pop_front());
      end else if (stray_done != stray_req) begin
        stray_done++;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEAD_BEEF;
      end else begin
        mem_rvalid = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base;
    reset          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    mem_ready      = 1'b0;
    mem_hold       = 1'b0;
    ir_ready       = 1'b0;
    budget         = 0;
    stray_req      = 0;

    fork
      // Monitor: pops the scoreboard on every delivered instruction.
      forever begin
        @(negedge clk);
        if (reset) begin
          if (ir_valid && ir_ready && !redirect_valid) begin
            budget--;
            if (sb.size() == 0) begin
              n_checks++;
              n_fail++;
              $display("FAIL unexpected_ir: got pc %0h with nothing expected", ir_pc);
            end else begin
              logic [31:0] e;
              e = sb.pop_front();
              chk("ir_pc", 64'(ir_pc), 64'(e));
              chk("ir", 64'(ir), 64'(rdata_of(e)));
            end
          end
          if (!ir_valid) chk("ir_idle_zero", {ir, ir_pc}, 64'd0);
        end
      end
      // Consumer: decode accepts exactly `budget` instructions.
      forever begin
        @(posedge clk);
        #2;
        ir_ready = (budget > 0);
      end
    join_none

    // Reset values
    @(negedge clk);
    chk("rst_mem_req", 64'(mem_req), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_ir_valid", 64'(ir_valid), 64'd0);
    chk("rst_ir", 64'(ir), 64'd0);
    chk("rst_ir_pc", 64'(ir_pc), 64'd0);

    // Stall with ir_ready low: four fetches fill the buffer, head stays at PC 0
    mem_ready = 1'b1;
    step(1);
    reset = 1'b1;
    wait_rvalid(20);
    chk("lat_before_push", 64'(ir_valid), 64'd0);
    @(negedge clk);
    chk("lat_after_push", 64'(ir_valid), 64'd1);
    step(10);
    @(negedge clk);
    chk("stall_accepts", 64'(acc_log.size()), 64'd4);
    chk("stall_mem_req", 64'(mem_req), 64'd0);
    chk("stall_ir_valid", 64'(ir_valid), 64'd1);
    chk("stall_ir_pc", 64'(ir_pc), 64'd0);
    chk("stall_ir", 64'(ir), 64'(rdata_of(32'h0)));

    // Streaming: PCs 0,4,...,44 in order, then buffer refills with 48..60
    step(1);
    expect_pcs(32'h0, 12);
    budget = 12;
    wait_sb(200);
    step(10);
    @(negedge clk);
    chk("refill_ir_pc", 64'(ir_pc), 64'h30);
    chk("refill_mem_req", 64'(mem_req), 64'd0);

    // Redirect with two requests outstanding
    step(1);
    base     = acc_log.size();
    mem_hold = 1'b1;
    expect_pcs(32'h30, 2);
    budget = 2;
    wait_sb(50);
    step(5);
    @(negedge clk);
    chk("t3_accepts", 64'(acc_log.size() - base), 64'd2);
    chk("t3_first_addr", 64'(acc_log[base]), 64'h40);
    chk("t3_mem_req_full", 64'(mem_req), 64'd0);
    step(1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    @(negedge clk);
    chk("t3_req_in_redirect", 64'(mem_req), 64'd0);
    step(1);
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("t3_ir_valid_drop", 64'(ir_valid), 64'd0);
    chk("t3_drain_req", 64'(mem_req), 64'd0);
    step(1);
    mem_hold = 1'b0;
    wait_rvalid(20);
    chk("t3_drain_req_1", 64'(mem_req), 64'd0);
    @(negedge clk);
    chk("t3_stale_2", 64'(mem_rvalid), 64'd1);
    chk("t3_drain_req_2", 64'(mem_req), 64'd0);
    @(negedge clk);
    chk("t3_resume_req", 64'(mem_req), 64'd1);
    chk("t3_resume_addr", 64'(mem_addr), 64'h100);
    expect_pcs(32'h100, 3);
    budget = 3;
    wait_sb(100);
    step(10);

    // Redirect coinciding with an ir handshake and an rvalid
    expect_pcs(32'h10C, 1);
    budget   = 1;
    mem_hold = 1'b1;
    wait_sb(50);
    step(4);
    mem_hold = 1'b0;
    step(1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    budget         = 1;
    expect_pcs(32'h200, 1);
    @(negedge clk);
    chk("t4_rvalid_coincide", 64'(mem_rvalid), 64'd1);
    chk("t4_ir_valid_coincide", 64'(ir_valid), 64'd1);
    chk("t4_req_in_redirect", 64'(mem_req), 64'd0);
    step(1);
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("t4_ir_valid_drop", 64'(ir_valid), 64'd0);
    chk("t4_no_drain_req", 64'(mem_req), 64'd1);
    chk("t4_no_drain_addr", 64'(mem_addr), 64'h200);
    wait_sb(50);
    step(10);

    // Stray response with nothing outstanding and a full buffer
    stray_req++;
    step(3);
    @(negedge clk);
    chk("t5_head_kept", 64'(ir_pc), 64'h204);
    step(1);
    expect_pcs(32'h204, 5);
    budget = 5;
    wait_sb(100);
    step(5);

    // Asynchronous reset mid-burst, then a stray response after release
    mem_hold = 1'b1;
    expect_pcs(32'h218, 3);
    budget = 3;
    wait_sb(50);
    step(2);
    #2;
    reset = 1'b0;
    #1;
    chk("t6_mem_req", 64'(mem_req), 64'd0);
    chk("t6_mem_addr", 64'(mem_addr), 64'd0);
    chk("t6_ir_valid", 64'(ir_valid), 64'd0);
    chk("t6_ir", 64'(ir), 64'd0);
    chk("t6_ir_pc", 64'(ir_pc), 64'd0);
    mem_hold = 1'b0;
    step(2);
    reset = 1'b1;
    stray_req++;
    base = acc_log.size();
    expect_pcs(32'h0, 10);
    budget = 10;
    wait_sb(200);
    chk("t6_restart_addr", 64'(acc_log[base]), 64'h0);
    step(2);
`ifdef IF_PERF_CNT_EN
    chk("perf_count", 64'(fetch_count), 64'd10);
`endif
    redirect_valid = 1'b1;
    redirect_pc    = 32'h300;
    step(1);
    redirect_valid = 1'b0;
    step(5);
`ifdef IF_PERF_CNT_EN
    chk("perf_after_redirect", 64'(fetch_count), 64'd10);
`endif
    @(negedge clk);
    chk("final_head_pc", 64'(ir_pc), 64'h300);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
